// File: rtl/enc8x3_event_encoder_pkg.sv
// Shared constants, index type and one-hot helper
// for the 8-line event encoder.
package enc_pkg;

   localparam int N_LINES = 8;
   localparam int IDX_W   = 3;

   typedef logic [IDX_W-1:0] idx_t;

   function automatic logic [N_LINES-1:0] onehot(input idx_t i);
      logic [N_LINES-1:0] m;
      m    = '0;
      m[i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/enc8x3_event_encoder_prio.sv
// Combinational 8-to-3 priority encoder.
// HI_WINS selects whether the highest or lowest request wins.
module prio_enc8
   import enc_pkg::*;
#(
   parameter bit HI_WINS = 1'b1
) (
   input  logic [N_LINES-1:0] req,
   output idx_t               idx,
   output logic               any
);

   always_comb begin
      idx = '0;
      any = |req;
      // The last match in scan order wins.
      if (HI_WINS) begin
         for (int i = 0; i < N_LINES; i++)
            if (req[i]) idx = idx_t'(i);
      end else begin
         for (int i = N_LINES - 1; i >= 0; i--)
            if (req[i]) idx = idx_t'(i);
      end
   end

endmodule

// File: rtl/enc8x3_event_encoder.sv
// Latches rising edges on 8 lines as sticky pending bits and
// presents them one at a time as 3-bit indices over valid/ready.
module enc8x3_event_encoder
   import enc_pkg::*;
#(
   parameter bit HI_WINS = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_LINES-1:0] in,
   input  logic               en,
   input  logic               out_ready,
   input  logic               clr_ovf,
   output idx_t               out,
   output logic               out_valid,
   output logic [N_LINES-1:0] pending,
   output logic               overflow
);

   logic [N_LINES-1:0] r_in_prev;
   logic [N_LINES-1:0] r_pending;
   idx_t               r_out;
   logic               r_out_valid;
   logic               r_overflow;

   logic [N_LINES-1:0] w_edge;
   logic [N_LINES-1:0] w_set;
   logic [N_LINES-1:0] w_clr;
   logic [N_LINES-1:0] w_pending_nxt;
   idx_t               w_idx;
   logic               w_any;
   logic               w_load;
   logic               w_ovf_set;

   prio_enc8 #(
      .HI_WINS (HI_WINS)
   ) u_prio (
      .req (r_pending),
      .idx (w_idx),
      .any (w_any)
   );

   assign w_edge = in & ~r_in_prev;
   assign w_set  = w_edge & {N_LINES{en}};

   // Load when empty, or when the held index is being accepted.
   assign w_load = w_any & (~r_out_valid | out_ready);
   assign w_clr  = w_load ? onehot(w_idx) : '0;

   assign w_pending_nxt = (r_pending & ~w_clr) | w_set;
   assign w_ovf_set     = |(w_set & r_pending & ~w_clr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_in_prev   <= '0;
         r_pending   <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_in_prev <= in;
         r_pending <= w_pending_nxt;
         if (w_ovf_set)
            r_overflow <= 1'b1;
         else if (clr_ovf)
            r_overflow <= 1'b0;
         if (w_load) begin
            r_out       <= w_idx;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign pending   = r_pending;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_enc8x3_event_encoder.sv
// Randomized and directed bench for enc8x3_event_encoder, run
// with both priority directions against a behavioural model.
module tb_enc8x3_event_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_v;
   logic       en;
   logic       ready;
   logic       clr;

   logic [2:0] out_h, out_l;
   logic       vld_h, vld_l;
   logic [7:0] pend_h, pend_l;
   logic       ovf_h, ovf_l;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   enc8x3_event_encoder #(.HI_WINS(1'b1)) dut_h (
      .clk(clk), .rst(rst), .in(in_v), .en(en),
      .out_ready(ready), .clr_ovf(clr),
      .out(out_h), .out_valid(vld_h),
      .pending(pend_h), .overflow(ovf_h)
   );

   enc8x3_event_encoder #(.HI_WINS(1'b0)) dut_l (
      .clk(clk), .rst(rst), .in(in_v), .en(en),
      .out_ready(ready), .clr_ovf(clr),
      .out(out_l), .out_valid(vld_l),
      .pending(pend_l), .overflow(ovf_l)
   );

   logic [12:0] obs [2];
   always_comb begin
      obs[0] = {out_h, vld_h, pend_h, ovf_h};
      obs[1] = {out_l, vld_l, pend_l, ovf_l};
   end

   // Model: index 0 = highest wins, index 1 = lowest wins
   logic [7:0] m_prev;
   logic [7:0] m_pend [2];
   logic [2:0] m_out  [2];
   logic       m_vld  [2];
   logic       m_ovf  [2];

   function automatic logic [12:0] m_vec(input int k);
      return {m_out[k], m_vld[k], m_pend[k], m_ovf[k]};
   endfunction

   task automatic model_reset();
      m_prev = '0;
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = '0;
         m_out[k]  = '0;
         m_vld[k]  = 1'b0;
         m_ovf[k]  = 1'b0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int         sel;
         bit         set_ovf;
         logic [7:0] newp;
         sel     = -1;
         set_ovf = 0;
         newp    = '0;
         if (m_pend[k] != 0 && (!m_vld[k] || ready)) begin
            for (int i = 0; i < 8; i++)
               if (m_pend[k][i] && (k == 0 || sel < 0)) sel = i;
         end
         for (int i = 0; i < 8; i++) begin
            bit e, keep;
            e    = in_v[i] && !m_prev[i] && en;
            keep = m_pend[k][i] && (i != sel);
            if (e && keep) set_ovf = 1;
            newp[i] = keep || e;
         end
         if (set_ovf) m_ovf[k] = 1'b1;
         else if (clr) m_ovf[k] = 1'b0;
         if (sel >= 0) begin
            m_out[k] = 3'(sel);
            m_vld[k] = 1'b1;
         end else if (m_vld[k] && ready) begin
            m_vld[k] = 1'b0;
         end
         m_pend[k] = newp;
      end
      m_prev = in_v;
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_v = '0; en = 1'b1; ready = 1'b1; clr = 1'b0;
      model_reset();
      #2;
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (obs[k] !== 13'd0)
            $display("FAIL reset[%0d] got %h want 0", k, obs[k]);
         else n_pass++;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_first_event();
      in_v = 8'h00; cycle();
      in_v = 8'h20; cycle();
      n_total++;
      if (pend_h !== 8'h20 || vld_h !== 1'b0 || pend_l !== 8'h20)
         $display("FAIL first_pend got %h/%b want 20/0", pend_h, vld_h);
      else n_pass++;
      cycle();
      n_total++;
      if (out_h !== 3'd5 || vld_h !== 1'b1 || pend_h !== 8'h00)
         $display("FAIL first_out got %0d/%b/%h want 5/1/00",
                  out_h, vld_h, pend_h);
      else n_pass++;
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (obs[k] !== m_vec(k))
            $display("FAIL first_model[%0d] got %h want %h", k, obs[k], m_vec(k));
         else n_pass++;
      end
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [2:0] eh [3];
      logic [2:0] el [3];
      eh = '{3'd7, 3'd4, 3'd0};
      el = '{3'd0, 3'd4, 3'd7};
      in_v = 8'h00; ready = 1'b1; cycle(); cycle();
      in_v = 8'h91; cycle();
      for (int j = 0; j < 3; j++) begin
         cycle();
         n_total++;
         if (out_h !== eh[j] || vld_h !== 1'b1 ||
             out_l !== el[j] || vld_l !== 1'b1)
            $display("FAIL b2b[%0d] got %0d/%0d want %0d/%0d",
                     j, out_h, out_l, eh[j], el[j]);
         else n_pass++;
      end
      cycle();
      n_total++;
      if (vld_h !== 1'b0 || vld_l !== 1'b0 || out_h !== 3'd0 || out_l !== 3'd7)
         $display("FAIL b2b_end got %b%b out %0d/%0d want 00 out 0/7",
                  vld_h, vld_l, out_h, out_l);
      else n_pass++;
   endtask

   task automatic test_hold();
      in_v = 8'h00; ready = 1'b1; cycle(); cycle();
      ready = 1'b0;
      in_v = 8'h08; cycle(); cycle();
      in_v = 8'h48;
      repeat (5) cycle();
      n_total++;
      if (out_h !== 3'd3 || vld_h !== 1'b1 || pend_h !== 8'h40 ||
          out_l !== 3'd3 || pend_l !== 8'h40)
         $display("FAIL hold got %0d/%h want 3/40", out_h, pend_h);
      else n_pass++;
      ready = 1'b1; cycle();
      n_total++;
      if (out_h !== 3'd6 || vld_h !== 1'b1 || out_l !== 3'd6 || pend_h !== 8'h00)
         $display("FAIL hold_next got %0d/%0d want 6/6", out_h, out_l);
      else n_pass++;
      cycle();
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (obs[k] !== m_vec(k))
            $display("FAIL hold_model[%0d] got %h want %h", k, obs[k], m_vec(k));
         else n_pass++;
      end
   endtask

   task automatic test_overflow();
      ready = 1'b0; in_v = 8'h00; cycle();
      in_v = 8'h01; cycle(); cycle();
      in_v = 8'h05; cycle();
      in_v = 8'h01; cycle();
      in_v = 8'h05; cycle();
      n_total++;
      if (ovf_h !== 1'b1 || pend_h[2] !== 1'b1 ||
          ovf_l !== 1'b1 || pend_l[2] !== 1'b1)
         $display("FAIL ovf_set got %b%b pend %h want 11 pend[2]=1",
                  ovf_h, ovf_l, pend_h);
      else n_pass++;
      clr = 1'b1; cycle(); clr = 1'b0;
      n_total++;
      if (ovf_h !== 1'b0 || ovf_l !== 1'b0)
         $display("FAIL ovf_clr got %b%b want 00", ovf_h, ovf_l);
      else n_pass++;
      ready = 1'b1; in_v = 8'h00;
      repeat (3) cycle();
   endtask

   task automatic test_enable();
      en = 1'b0;
      in_v = 8'hFF; cycle();
      in_v = 8'h00; cycle();
      in_v = 8'hFF; cycle();
      n_total++;
      if (pend_h !== 8'h00 || vld_h !== 1'b0 || pend_l !== 8'h00)
         $display("FAIL en_off got %h/%b want 00/0", pend_h, vld_h);
      else n_pass++;
      en = 1'b1;
      repeat (3) cycle();
      n_total++;
      if (pend_h !== 8'h00 || vld_h !== 1'b0 || vld_l !== 1'b0)
         $display("FAIL en_steady got %h/%b want 00/0", pend_h, vld_h);
      else n_pass++;
      in_v = 8'h00; cycle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         in_v  = in_v ^ 8'($urandom & $urandom);
         en    = ($urandom_range(0, 3) != 0);
         ready = 1'($urandom_range(0, 1));
         clr   = ($urandom_range(0, 7) == 0);
         cycle();
         for (int k = 0; k < 2; k++) begin
            n_total++;
            if (obs[k] !== m_vec(k))
               $display("FAIL rand[%0d][%0d] got %h want %h",
                        n, k, obs[k], m_vec(k));
            else n_pass++;
         end
      end
      en = 1'b1; clr = 1'b0;
   endtask

   task automatic test_reset_mid();
      ready = 1'b1; in_v = 8'h00;
      repeat (10) cycle();
      ready = 1'b0;
      in_v = 8'h01; cycle(); cycle();
      in_v = 8'h0D; cycle();
      n_total++;
      if (pend_h !== 8'h0C || vld_h !== 1'b1 || pend_l !== 8'h0C)
         $display("FAIL rmid_pre got %h/%b want 0C/1", pend_h, vld_h);
      else n_pass++;
      #2 rst = 1'b1;
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (obs[k] !== 13'd0)
            $display("FAIL rmid[%0d] got %h want 0", k, obs[k]);
         else n_pass++;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_first_event();
      test_back_to_back();
      test_hold();
      test_overflow();
      test_enable();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
